// File: rtl/pattern_round.sv
// One memory-game round: generate an LFSR pattern, play it on the LEDs,
// then score the player's button presses against it.
module pattern_round #(
  parameter int          SHOW_CYCLES    = 50_000_000,
  parameter int          GAP_CYCLES     = 25_000_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [7:0] botton,
  output logic [7:0] led,
  output logic       busy,
  output logic       round_done,
  output logic [3:0] hit_count,
  output logic       round_pass
);

  localparam int TMAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [7:0]    prev_q;
  logic [3:0]    len_q, len_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    hit_q, hit_d;
  logic          pass_q, pass_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    pat_q [8];

  logic [7:0] edge_w;
  logic [7:0] tgt;
  logic       last;
  logic       lvl_ok;
  logic [3:0] lvl_len;

  assign edge_w = botton & ~prev_q;
  assign tgt    = 8'b1 << pat_q[idx_q];
  assign last   = ({1'b0, idx_q} == len_q - 4'd1);

  always_comb begin
    lvl_ok  = 1'b1;
    lvl_len = 4'd4;
    unique case (level)
      3'b001:  lvl_len = 4'd4;
      3'b010:  lvl_len = 4'd6;
      3'b100:  lvl_len = 4'd8;
      default: lvl_ok  = 1'b0;
    endcase
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11 (right-shift form)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
      prev_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};
      prev_q <= botton;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == GEN) pat_q[idx_q] <= lfsr_q[2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= 4'd4;
      idx_q   <= '0;
      hit_q   <= '0;
      pass_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      pass_q  <= pass_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    pass_d  = pass_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (start && lvl_ok) begin
          len_d   = lvl_len;
          idx_d   = '0;
          hit_d   = '0;
          pass_d  = 1'b0;
          state_d = GEN;
        end
      end
      GEN: begin
        idx_d = idx_q + 3'd1;
        if (last) begin
          idx_d   = '0;
          tmr_d   = '0;
          state_d = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tmr_q == TW'(SHOW_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = SHOW_OFF;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SHOW_OFF: begin
        if (tmr_q == TW'(GAP_CYCLES - 1)) begin
          tmr_d = '0;
          if (last) begin
            idx_d   = '0;
            state_d = INPUT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SHOW_ON;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      INPUT: begin
        if (edge_w != '0) begin
          // a multi-button press can never equal the one-hot target
          if (edge_w == tgt) hit_d = hit_q + 4'd1;
          tmr_d = '0;
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 3'd1;
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DONE: begin
        pass_d  = (hit_q == len_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led        = '0;
    busy       = (state_q != IDLE);
    round_done = (state_q == DONE);
    unique case (state_q)
      SHOW_ON: led = tgt;
      INPUT:   led = botton;
      default: led = '0;
    endcase
  end

  assign hit_count  = hit_q;
  assign round_pass = (state_q == DONE) ? (hit_q == len_q) : pass_q;

endmodule

// File: tb/tb_pattern_round.sv
// Scoreboard bench for pattern_round with short timing parameters.
module tb_pattern_round;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] level = 3'b000;
  logic [7:0] botton = 8'h00;
  logic [7:0] led;
  logic       busy;
  logic       round_done;
  logic [3:0] hit_count;
  logic       round_pass;

  pattern_round #(
    .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .level(level),
    .botton(botton), .led(led), .busy(busy),
    .round_done(round_done), .hit_count(hit_count),
    .round_pass(round_pass)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [4:0] sb_q [$];
  logic [2:0] exp_pat [8];
  logic [15:0] m_lfsr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference LFSR: x^16+x^14+x^13+x^11, shift right, feedback into bit 15
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                    m_lfsr[15:1]};
  end

  always @(negedge clk) begin
    if (rst && round_done) begin
      if (sb_q.size() == 0) begin
        chk("round_done_unexpected", 1, 0);
      end else begin
        logic [4:0] e;
        e = sb_q.pop_front();
        chk("hit_count", 32'(hit_count), 32'(e[4:1]));
        chk("round_pass", 32'(round_pass), 32'(e[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [2:0] lvl, input int len,
                             input bit hold, input bit busy_start);
    start = 1'b1;
    level = lvl;
    tick();
    start = 1'b0;
    chk("gen_busy", 32'(busy), 1);
    chk("gen_hit_clr", 32'(hit_count), 0);
    for (int k = 0; k < len; k++) begin
      exp_pat[k] = m_lfsr[2:0];
      tick();
    end
    if (hold) botton = 8'b1 << ((exp_pat[0] + 3'd1) % 8);
    for (int s = 0; s < len; s++) begin
      for (int c = 0; c < 4; c++) begin
        start = busy_start && s == 1 && c == 0;
        if (start) level = 3'b100;
        if (c == 0 || c == 3) begin
          chk($sformatf("show_led%0d", s), 32'(led), 32'(8'b1 << exp_pat[s]));
          chk("show_busy", 32'(busy), 1);
        end
        tick();
      end
      start = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (c == 0) chk("gap_led", 32'(led), 0);
        tick();
      end
    end
  endtask

  task automatic press(input logic [7:0] b);
    botton = b;
    #1;
    chk("echo_led", 32'(led), 32'(b));
    tick();
    botton = 8'h00;
    tick();
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(round_done), 0);
    chk("rst_hit", 32'(hit_count), 0);
    chk("rst_pass", 32'(round_pass), 0);
    tick();
    rst = 1'b1;
    tick();

    // L1, all correct
    start_round(3'b001, 4, 0, 0);
    sb_q.push_back({4'd4, 1'b1});
    for (int k = 0; k < 4; k++) press(8'b1 << exp_pat[k]);
    wait_idle(10, n);
    chk("hold_hit", 32'(hit_count), 4);
    chk("hold_pass", 32'(round_pass), 1);

    // L2: step 1 double press, step 3 wrong button
    start_round(3'b010, 6, 0, 0);
    sb_q.push_back({4'd4, 1'b0});
    for (int k = 0; k < 6; k++) begin
      logic [7:0] b;
      b = 8'b1 << exp_pat[k];
      if (k == 1) b = b | (8'b1 << ((exp_pat[k] + 3'd4) % 8));
      if (k == 3) b = 8'b1 << ((exp_pat[k] + 3'd1) % 8);
      press(b);
    end
    wait_idle(10, n);

    // L3: three correct then timeout
    start_round(3'b100, 8, 0, 0);
    sb_q.push_back({4'd3, 1'b0});
    for (int k = 0; k < 3; k++) press(8'b1 << exp_pat[k]);
    wait_idle(60, n);
    chk("timeout_cycles", 32'(n), 20);

    // invalid level start ignored
    start = 1'b1;
    level = 3'b000;
    tick();
    start = 1'b0;
    chk("bad_lvl_busy", 32'(busy), 0);
    tick();
    chk("bad_lvl_busy2", 32'(busy), 0);
    chk("bad_lvl_hit", 32'(hit_count), 3);

    // start while busy ignored; button held into INPUT is not a press
    start_round(3'b001, 4, 1, 1);
    sb_q.push_back({4'd4, 1'b1});
    chk("held_echo", 32'(led), 32'(botton));
    tick();
    tick();
    botton = 8'h00;
    tick();
    for (int k = 0; k < 4; k++) press(8'b1 << exp_pat[k]);
    wait_idle(10, n);

    // reset in SHOW_ON
    start = 1'b1;
    level = 3'b010;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_led", 32'(led), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_hit", 32'(hit_count), 0);
    tick();
    rst = 1'b1;
    tick();
    start_round(3'b001, 4, 0, 0);
    sb_q.push_back({4'd4, 1'b1});
    for (int k = 0; k < 4; k++) press(8'b1 << exp_pat[k]);
    wait_idle(10, n);
    tick();
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
